reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_clr_seq.sv | 59 +++++
 rtl/reg_file_param.sv | 105 ++++++++++
 tb/tb_reg_file_param.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Holds the bulk-clear state encoding used by the sequencer and the top.
package reg_file_pkg;

  localparam int DATA_W_DEF = 19;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Bulk-clear sequencer: sweeps clr_ptr over every register, one per cycle (DEPTH cycles).
// Starts in CLEAR out of reset; clr_req is honoured only in IDLE, so a sweep cannot be extended.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_ptr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        // The pointer wraps to zero on the final entry, leaving it ready for the next sweep.
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == PTR_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign clr_we  = (state_q == CLEAR);
  assign clr_ptr = clr_ptr_q;

endmodule

// File: rtl/reg_file_param.sv
// 2-read/1-write register file with optional hard-zero r0 and write-to-read bypass.
// Reads are combinational; writes land at the clock edge, and writes arriving during a clear are dropped and flagged.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_acc;
  logic              wr_drop_q, wr_drop_d;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_we;

  reg_file_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_ptr (clr_ptr),
    .clr_we  (clr_we)
  );

  always_comb begin
    wr_acc    = wr_en && !busy && !(ZERO_REG && (wr_addr == '0));
    wr_drop_d = wr_en && busy;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    // User writes only happen in IDLE and the sweep only in CLEAR, so the two never collide.
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // The array carries no reset; the sweep after reset release zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              bsy,
    input logic              wacc,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if (ZERO_REG && (addr == '0)) begin
      res = '0;
    end else if (bsy) begin
      res = '0;
    end else if (BYPASS && wacc && (waddr == addr)) begin
      res = wdata;
    end
    return res;
  endfunction

  always_comb begin
    rd_data1 = rd_sel(rd_addr1, mem_q[rd_addr1], busy, wr_acc, wr_addr, wr_data);
    rd_data2 = rd_sel(rd_addr2, mem_q[rd_addr2], busy, wr_acc, wr_addr, wr_data);
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: reset sweep, writes, r0, bypass, bulk clear, drops, reset mid-sweep.
// A second instance with BYPASS=0 shares all inputs to show the non-forwarded read.
module tb_reg_file_param;

  localparam int DW = 19;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, clr_req;
  logic [DW-1:0] rd_data1, rd_data2, rd_data1_nb, rd_data2_nb;
  logic          busy, wr_drop, busy_nb, wr_drop_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk (clk), .rst_n (rst_n),
    .rd_addr1 (rd_addr1), .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1), .rd_data2 (rd_data2),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .clr_req (clr_req), .busy (busy), .wr_drop (wr_drop)
  );

  reg_file_param #(.BYPASS (1'b0)) dut_nb (
    .clk (clk), .rst_n (rst_n),
    .rd_addr1 (rd_addr1), .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1_nb), .rd_data2 (rd_data2_nb),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .clr_req (clr_req), .busy (busy_nb), .wr_drop (wr_drop_nb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops; bounded so a stuck sequencer still ends the run.
  task automatic wait_idle(output int edges);
    edges = 0;
    while (busy && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a);
      rd_addr2 = 4'(15 - a);
      #1;
      check_eq($sformatf("%s_rd1_r%0d", tag, a), 32'(rd_data1), 32'h0);
      check_eq($sformatf("%s_rd2_r%0d", tag, 15 - a), 32'(rd_data2), 32'h0);
    end
  endtask

  function automatic logic [DW-1:0] fill_val(input int i);
    return DW'(i * 32'h1111 + 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr1 = 4'd5; rd_addr2 = 4'd9;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'h1);
    check_eq("rst_busy_nb", 32'(busy_nb), 32'h1);
    check_eq("rst_wr_drop", 32'(wr_drop), 32'h0);
    check_eq("rst_rd1", 32'(rd_data1), 32'h0);
    check_eq("rst_rd2", 32'(rd_data2), 32'h0);

    // Release: full sweep, then everything reads zero
    rst_n = 1'b1;
    wait_idle(e);
    check_eq("init_sweep_len", 32'(e), 32'd16);
    check_eq("init_busy_low", 32'(busy), 32'h0);
    check_all_zero("init");

    // r5 written, read on both ports; r0 write discarded without a drop
    rd_addr1 = 4'd5; rd_addr2 = 4'd5;
    do_write(4'd5, 19'h7FFFF);
    #1;
    check_eq("r5_rd1", 32'(rd_data1), 32'h7FFFF);
    check_eq("r5_rd2", 32'(rd_data2), 32'h7FFFF);
    check_eq("r5_no_drop", 32'(wr_drop), 32'h0);
    rd_addr1 = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 19'h12345;
    #1;
    check_eq("r0_no_bypass", 32'(rd_data1), 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check_eq("r0_reads_zero", 32'(rd_data1), 32'h0);
    check_eq("r0_no_drop", 32'(wr_drop), 32'h0);

    // Same-cycle bypass on r3; port 2 on r5 unaffected
    rd_addr1 = 4'd3; rd_addr2 = 4'd5;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 19'h00ABC;
    #1;
    check_eq("bypass_rd1", 32'(rd_data1), 32'h00ABC);
    check_eq("nobypass_rd1", 32'(rd_data1_nb), 32'h0);
    check_eq("bypass_rd2_other", 32'(rd_data2), 32'h7FFFF);
    check_eq("nobypass_rd2_other", 32'(rd_data2_nb), 32'h7FFFF);
    tick();
    wr_en = 1'b0;
    #1;
    check_eq("nobypass_after_edge", 32'(rd_data1_nb), 32'h00ABC);

    // Fill r1..r15, then clear with a simultaneous write to r7
    for (int i = 1; i < 16; i++) do_write(4'(i), fill_val(i));
    rd_addr1 = 4'd15; rd_addr2 = 4'd1;
    #1;
    check_eq("fill_r15", 32'(rd_data1), 32'h10000);
    check_eq("fill_r1", 32'(rd_data2), 32'h01112);
    rd_addr1 = 4'd7;
    #1;
    check_eq("fill_r7", 32'(rd_data1), 32'h07778);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 19'h1; clr_req = 1'b1;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    check_eq("clr_busy", 32'(busy), 32'h1);
    check_eq("clr_wr_not_dropped", 32'(wr_drop), 32'h0);
    wait_idle(e);
    check_eq("clr_sweep_len", 32'(e), 32'd16);
    check_all_zero("clr");

    // Writes during a sweep are dropped; clr_req mid-sweep does not extend it
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 19'h00055;
    tick();
    wr_en = 1'b0;
    check_eq("drop_r9_pulse", 32'(wr_drop), 32'h1);
    check_eq("drop_r9_pulse_nb", 32'(wr_drop_nb), 32'h1);
    tick();
    check_eq("drop_one_cycle", 32'(wr_drop), 32'h0);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 19'h00066; clr_req = 1'b1;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    check_eq("drop_r1_pulse", 32'(wr_drop), 32'h1);
    wait_idle(e);
    check_eq("no_extend_len", 32'(e + 3), 32'd16);
    rd_addr1 = 4'd9; rd_addr2 = 4'd1;
    #1;
    check_eq("r9_dropped", 32'(rd_data1), 32'h0);
    check_eq("r1_dropped", 32'(rd_data2), 32'h0);

    // Reset at sweep cycle 8 restarts a full sweep
    do_write(4'd12, 19'h04321);
    rd_addr1 = 4'd12;
    #1;
    check_eq("r12_written", 32'(rd_data1), 32'h04321);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'h1);
    check_eq("midrst_rd1", 32'(rd_data1), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle(e);
    check_eq("midrst_sweep_len", 32'(e), 32'd16);
    check_eq("midrst_idle", 32'(busy), 32'h0);
    rd_addr1 = 4'd12;
    #1;
    check_eq("midrst_r12_zero", 32'(rd_data1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
